// File: rtl/alu_sequencer.sv
// Multi-cycle, non-pipelined controller that decodes one 32-bit instruction at a time.
// It drives register-file reads, ALU execution, data-memory access and register write-back.
module alu_sequencer #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 5,
    parameter int MEM_AW  = 9,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_res_lo,
    input  logic [DATA_W-1:0] alu_res_hi,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    // Opcode map: 4..16 are ALU ops, and alu_op is the opcode minus 4.
    localparam logic [5:0] OP_MOV   = 6'd0;
    localparam logic [5:0] OP_MOVI  = 6'd1;
    localparam logic [5:0] OP_LOAD  = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_NOT   = 6'd9;
    localparam logic [5:0] OP_NEG   = 6'd10;
    localparam logic [5:0] OP_LLSH  = 6'd11;
    localparam logic [5:0] OP_LRSH  = 6'd12;
    localparam logic [5:0] OP_MUL   = 6'd13;
    localparam logic [5:0] OP_DIV   = 6'd14;
    localparam logic [5:0] OP_LAST  = 6'd16;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_EXEC_M,
        S_MEM,
        S_WB1,
        S_WB2,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            state;
    logic [31:0]       code;
    logic [DATA_W-1:0] res_hi;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        opcode;
    logic              is_muldiv;
    logic [DATA_W-1:0] b_masked;

    assign opcode    = code[31:26];
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

    // Unary ops see a zero B operand; shifts only ever see a 4-bit amount.
    always_comb begin
        b_masked = rf_rdata2;
        if (opcode == OP_NEG || opcode == OP_NOT)
            b_masked = '0;
        else if (opcode == OP_LLSH || opcode == OP_LRSH)
            b_masked = {{(DATA_W-4){1'b0}}, rf_rdata2[3:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            code        <= '0;
            res_hi      <= '0;
            cnt         <= '0;
            instr_ready <= 1'b1;
            rf_raddr1   <= '0;
            rf_raddr2   <= '0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_start   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            rf_we     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        code        <= instr;
                        rf_raddr1   <= instr[4:0];
                        rf_raddr2   <= instr[9:5];
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode > OP_LAST) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_FAULT;
                    end else if (opcode == OP_MOVI) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= code[20:16];
                        rf_wdata <= code[15:0];
                        state    <= S_WB1;
                    end else begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    cnt <= '0;
                    if (opcode == OP_MOV) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= code[20:16];
                        rf_wdata <= rf_rdata1;
                        state    <= S_WB1;
                    end else if (opcode == OP_LOAD) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= code[8:0];
                        state    <= S_MEM;
                    end else if (opcode == OP_STORE) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= code[24:16];
                        mem_wdata <= rf_rdata1;
                        state     <= S_MEM;
                    end else begin
                        alu_op    <= 4'(opcode - 6'd4);
                        alu_a     <= rf_rdata1;
                        alu_b     <= b_masked;
                        alu_start <= is_muldiv;
                        state     <= is_muldiv ? S_EXEC_M : S_EXEC;
                    end
                end
                S_EXEC: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= code[20:16];
                    rf_wdata <= alu_res_lo;
                    state    <= S_WB1;
                end
                S_EXEC_M: begin
                    if (alu_done) begin
                        res_hi   <= alu_res_hi;
                        rf_we    <= 1'b1;
                        rf_waddr <= code[20:16];
                        rf_wdata <= alu_res_lo;
                        state    <= S_WB1;
                    end else if (cnt == CNT_LAST) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Request, address and data stay frozen until the acknowledge or the timeout.
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (opcode == OP_STORE) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rf_we    <= 1'b1;
                            rf_waddr <= code[20:16];
                            rf_wdata <= mem_rdata;
                            state    <= S_WB1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The high word goes out second so it wins when both destinations match.
                S_WB1: begin
                    if (is_muldiv) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= code[25:21];
                        rf_wdata <= res_hi;
                        state    <= S_WB2;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WB2: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE, S_FAULT: begin
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that accepts one 32-bit instruction word at a time and decodes opcode code[31:26].
- Sequences register-file read, ALU execution (single-cycle or multi-cycle MUL/DIV), data-memory access and register write-back.
- Sits between the instruction fetch stage and the shared ALU / register file / data memory.
- Only one instruction is in flight; it is not pipelined.

Parameters:
- DATA_W, 16, datapath width.
- REG_AW, 5, register address width.
- MEM_AW, 9, data-memory address width.
- TIMEOUT, 64, maximum cycles to wait for alu_done or mem_ack before aborting.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  instruction word.
- rf_raddr1  out  5  register read port 1 address, from code[4:0] (Rsrc1).
- rf_raddr2  out  5  register read port 2 address, from code[9:5] (Rsrc2).
- rf_rdata1  in  16  read data port 1; synchronous, 1-cycle read latency.
- rf_rdata2  in  16  read data port 2; synchronous, 1-cycle read latency.
- alu_op  out  4  ALU function, = opcode-4 for opcodes 000100..010000.
- alu_a  out  16  ALU operand A (Rsrc1 value).
- alu_b  out  16  ALU operand B (Rsrc2 value).
- alu_start  out  1  one-cycle pulse that launches MUL/DIV.
- alu_done  in  1  MUL/DIV result valid.
- alu_res_lo  in  16  ALU result, low word.
- alu_res_hi  in  16  ALU result, high word (MUL high product / DIV remainder).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  9  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_ack  in  1  memory request complete.
- rf_we  out  1  register write enable.
- rf_waddr  out  5  register write address.
- rf_wdata  out  16  register write data.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse with done on undefined opcode or timeout.

Behaviour:
- Interface: clock port clk, reset port rst; one clock; reset is synchronous and active-high.
- Reset: state=IDLE, instr_ready=1. All other outputs are 0: busy, done, illegal, alu_start, mem_req, mem_we, rf_we, addresses, data, alu_op. Timeout counter is 0.
- Reset asserted in any state wins over all other events. An in-flight instruction is dropped with no write-back and no done pulse.

States and transitions:
- IDLE: instr_ready=1. Capture instr when instr_valid && instr_ready, then go to DECODE. instr_ready is 0 in every other state.
- DECODE: drive rf_raddr1/2.
  - Undefined opcode (>010000) → FAULT.
  - MOV-imm (000001) → WB1.
  - Otherwise → READ.
- READ: rf data valid this cycle; latch it into opA/opB.
  - MOV (000000) → WB1.
  - LOAD/STORE → MEM.
  - MUL/DIV → EXEC_M.
  - Others → EXEC.
- EXEC: drive alu_op/alu_a/alu_b; latch alu_res_lo → WB1.
- EXEC_M: alu_start=1 for the first cycle only. Wait for alu_done, then latch lo/hi → WB1. Counter reaches TIMEOUT → FAULT.
- MEM: hold mem_req=1 and stable address/data until mem_ack (ack in the same cycle as req is allowed).
  - LOAD: mem_addr=code[8:0], mem_we=0; latch mem_rdata → WB1.
  - STORE: mem_addr=code[24:16], mem_we=1, mem_wdata=opA; → DONE, no write-back.
  - Counter reaches TIMEOUT → FAULT with mem_req dropped.
- WB1: rf_we=1, rf_waddr=code[20:16] (Rdst1). rf_wdata is:
  - result_lo for ALU ops;
  - opA for MOV;
  - code[15:0] for MOV-imm;
  - mem data for LOAD.
  - MUL/DIV → WB2; otherwise → DONE.
- WB2: rf_we=1, rf_waddr=code[25:21] (Rdst2), rf_wdata=result_hi → DONE.
- DONE: done=1 for one cycle → IDLE.
- FAULT: done=1 and illegal=1 for one cycle → IDLE; no register or memory write.

Rules:
- busy=1 in every state except IDLE.
- Timeout counter clears on entry to EXEC_M/MEM. TIMEOUT counts cycles spent in the wait state.
- A Rdst1==Rdst2 collision in MUL/DIV: WB2 overwrites and the high word wins.
- Single-cycle op latency: accept edge to done = 5 cycles (DECODE, READ, EXEC, WB1, DONE). A new instruction can be accepted the cycle after done.
- NEG/NOT are unary (operand A only). LLSH/LRSH shift amount = opB[3:0]. Wider values wrap modulo 16, enforced by the sequencer masking alu_b.

Test Plan:
1. Reset mid-EXEC_M with alu_done never asserted → next cycle state IDLE, instr_ready=1, no rf_we, no done.
2. ADD, rf_rdata1=0x0003, rf_rdata2=0x0005, alu_res_lo=0x0008 → rf_we for one cycle with waddr=Rdst1, wdata=0x0008; done exactly 5 cycles after accept.
3. MUL, alu_done 3 cycles after alu_start, lo=0x2000, hi=0x0001 → alu_start is a single pulse; WB1 writes 0x2000 to Rdst1, then WB2 writes 0x0001 to Rdst2.
4. STORE with code[24:16]=0x1A5, opA=0xBEEF, mem_ack held off 4 cycles → mem_req/addr/wdata stable for 5 cycles, no rf_we, then done.
5. Opcode 111111 → illegal and done together one cycle after DECODE; no rf_we/mem_req. Also: LOAD with mem_ack never → illegal at TIMEOUT.
6. MOV-imm 0x1234 with instr_valid held high continuously → write 0x1234 to Rdst1; instr_ready low from accept until IDLE; second instruction accepted exactly once.
